reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent downstream reset outputs, legal range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 10: clock edges before channel 0 is released, minimum 1.
REQ-003 Parameter STAGE_GAP, default 4: clock edges between successive channel releases, minimum 1.
REQ-004 Parameter RUN_CYCLES, default 500: clock edges in RUN before done asserts; 0 means run forever.
REQ-005 Parameter CNT_WIDTH, default 16: width of the internal counter and cycle_count.
REQ-006 clock  input  1  the single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; the environment deasserts it away from the rising edge of clock.
REQ-008 soft_restart  input  1  single-cycle request to restart the whole sequence.
REQ-009 pause  input  1  level; freezes the counter and state while high.
REQ-010 channel_reset  output  CHANNELS  per-channel reset for downstream machines, active-high (asserted = `ENABLE).
REQ-011 phase  output  2  current state encoding.
REQ-012 run_active  output  1  high while in RUN.
REQ-013 done  output  1  high in DONE; replaces the fixed-time bench stop.
REQ-014 cycle_count  output  CNT_WIDTH  count of RUN edges elapsed; saturates at all-ones.

Function
REQ-015 FSM states: HOLD=0, RELEASE=1, RUN=2, DONE=3, driven on phase.
REQ-016 Edge n is the n-th rising clock edge after reset deasserts, counting from 1.
REQ-017 channel_reset[k] deasserts at edge HOLD_CYCLES + k*STAGE_GAP, in ascending k, and stays deasserted until restart.
REQ-018 HOLD->RELEASE at edge HOLD_CYCLES; RELEASE->RUN at the edge releasing channel CHANNELS-1; with CHANNELS=1, HOLD->RUN directly.
REQ-019 cycle_count is 0 on RUN entry and increments by 1 per RUN edge.
REQ-020 RUN->DONE at the edge where cycle_count would reach RUN_CYCLES; done and phase=DONE are registered at that edge; cycle_count holds RUN_CYCLES.
REQ-021 DONE is terminal until reset or soft_restart; channel_reset stays all deasserted in DONE.
REQ-022 While pause=1 and soft_restart=0, state, counter, cycle_count and channel_reset hold; edges do not count toward REQ-017/020.
REQ-023 soft_restart=1 at any edge, in any state: next state HOLD, counter and cycle_count 0, all channel_reset asserted; REQ-016 numbering restarts from the following edge.
REQ-024 soft_restart has priority over pause; a pause/release coinciding with a channel release defers that release by the paused edges only.
REQ-025 Counter overflow is impossible for legal parameters; elaboration fails if HOLD_CYCLES, CHANNELS*STAGE_GAP or RUN_CYCLES exceeds 2^CNT_WIDTH-1.
REQ-026 All outputs are registered; no combinational path from input to output.

Reset
REQ-027 reset low immediately forces: phase=HOLD, channel_reset all ones, run_active=0, done=0, cycle_count=0, counter=0.
REQ-028 Reset asserted mid-sequence (any state) aborts it with the same values; no partial release survives.

Structure
REQ-029 State encodings and `ENABLE/`DISABLE levels live in the shared defines header used by the machine.
REQ-030 One sub-module, seq_counter: CNT_WIDTH loadable up-counter with clear, enable and saturation, used for both stage timing and cycle_count.

Verification
REQ-031 Defaults, reset released then idle: channel_reset 2'b11 -> 2'b10 at edge 10 -> 2'b00 at edge 14; run_active from edge 14; done at edge 514, cycle_count=500.
REQ-032 pause high for edges 12..16: channel 1 released at edge 19 instead of 14; done at edge 519.
REQ-033 soft_restart pulse at edge 100 (RUN): channel_reset=2'b11, phase=0 after edge 100; channel 0 releases at edge 110, channel 1 at edge 114.
REQ-034 reset low asynchronously at edge 200 + 5 ns: all outputs take reset values before the next edge; sequence replays from REQ-031 after release.
REQ-035 CHANNELS=4, STAGE_GAP=1, RUN_CYCLES=0: releases at edges 10,11,12,13; done never asserts over 70000 edges; cycle_count saturates at 16'hFFFF.
REQ-036 soft_restart and pause both high in DONE: next phase=HOLD, done=0.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
// Holds the phase encoding driven on the phase output and the ENABLE/DISABLE
// levels used for the downstream channel resets (active-high).
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } phase_t;

  localparam logic ENABLE  = 1'b1;  // channel held in reset
  localparam logic DISABLE = 1'b0;  // channel released

  // Width of an index that can address n channels (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_counter.sv
// seq_counter: loadable up-counter with synchronous clear, load and enable.
// Saturates at all-ones instead of wrapping.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset, clears the count
//   clear      - synchronous clear to zero (highest priority)
//   load       - synchronous load of load_value
//   load_value - value taken when load is high
//   enable     - count up by one when neither clear nor load is high
//   count      - current count
module seq_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases CHANNELS downstream resets one after another
// (channel 0 after HOLD_CYCLES edges, then one every STAGE_GAP edges), then
// counts RUN_CYCLES edges in RUN before entering the terminal DONE phase.
// Ports:
//   clock         - system clock, rising edge
//   reset         - asynchronous active-low reset, aborts the sequence
//   soft_restart  - one-cycle request to restart from HOLD (beats pause)
//   pause         - level; freezes all sequencing state while high
//   channel_reset - per-channel reset, active-high, released in ascending order
//   phase         - current phase (HOLD/RELEASE/RUN/DONE)
//   run_active    - high while in RUN
//   done          - high in DONE
//   cycle_count   - RUN edges elapsed, saturating
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGE_GAP   = 4,
  parameter int RUN_CYCLES  = 500,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 soft_restart,
  input  logic                 pause,
  output logic [CHANNELS-1:0]  channel_reset,
  output logic [1:0]           phase,
  output logic                 run_active,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int     IDX_W   = idx_width(CHANNELS);
  localparam longint CNT_MAX = longint'((64'd1 << CNT_WIDTH) - 64'd1);

  // Parameter legality is enforced at elaboration time.
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("reset_sequencer: CHANNELS must be 1..8");
  end
  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range for CNT_WIDTH");
  end
  if (STAGE_GAP < 1 || longint'(CHANNELS) * longint'(STAGE_GAP) > CNT_MAX) begin : g_bad_gap
    $error("reset_sequencer: CHANNELS*STAGE_GAP out of range for CNT_WIDTH");
  end
  if (RUN_CYCLES < 0 || longint'(RUN_CYCLES) > CNT_MAX) begin : g_bad_run
    $error("reset_sequencer: RUN_CYCLES out of range for CNT_WIDTH");
  end

  // One extra bit so "count + 1" comparisons never wrap.
  typedef logic [CNT_WIDTH:0] ext_t;

  localparam ext_t             HOLD_LIM = ext_t'(HOLD_CYCLES);
  localparam ext_t             GAP_LIM  = ext_t'(STAGE_GAP);
  localparam ext_t             RUN_LIM  = ext_t'(RUN_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  phase_t               state_q, state_d;
  logic [CHANNELS-1:0]  chan_q, chan_d;
  logic [IDX_W-1:0]     idx_q, idx_d;       // next channel to release
  logic [CNT_WIDTH-1:0] stage_count, run_count;
  logic                 stage_clear, stage_load, stage_en;
  logic                 run_clear, run_en;
  logic                 stage_hit, run_hit;

  // The stage counter restarts from zero after every release, so it only
  // ever has to reach HOLD_CYCLES or STAGE_GAP.
  seq_counter #(.WIDTH(CNT_WIDTH)) u_stage_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (stage_clear),
    .load       (stage_load),
    .load_value ('0),
    .enable     (stage_en),
    .count      (stage_count)
  );

  seq_counter #(.WIDTH(CNT_WIDTH)) u_run_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (run_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (run_en),
    .count      (run_count)
  );

  // A hit means the current edge is the one that completes the interval.
  assign stage_hit = (ext_t'(stage_count) + ext_t'(1)) ==
                     ((state_q == HOLD) ? HOLD_LIM : GAP_LIM);
  assign run_hit   = (RUN_CYCLES != 0) &&
                     ((ext_t'(run_count) + ext_t'(1)) == RUN_LIM);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    idx_d       = idx_q;
    stage_clear = 1'b0;
    stage_load  = 1'b0;
    stage_en    = 1'b0;
    run_clear   = 1'b0;
    run_en      = 1'b0;

    if (soft_restart) begin
      state_d     = HOLD;
      chan_d      = {CHANNELS{ENABLE}};
      idx_d       = '0;
      stage_clear = 1'b1;
      run_clear   = 1'b1;
    end else if (!pause) begin
      case (state_q)
        HOLD, RELEASE: begin
          stage_en = 1'b1;
          if (stage_hit) begin
            chan_d[idx_q] = DISABLE;
            stage_load    = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
            end else begin
              state_d = RELEASE;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        RUN: begin
          run_en = 1'b1;
          if (run_hit) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // Terminal until reset or soft_restart.
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // run_active and done are registered from the next state so they change on
  // the same edge as phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= HOLD;
      chan_q     <= {CHANNELS{ENABLE}};
      idx_q      <= '0;
      run_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      idx_q      <= idx_d;
      run_active <= (state_d == RUN);
      done       <= (state_d == DONE);
    end
  end

  assign channel_reset = chan_q;
  assign phase         = state_q;
  assign cycle_count   = run_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Two instances share one clock: dut1 with default parameters takes directed
// and randomized stimulus; dut2 (CHANNELS=4, STAGE_GAP=1, RUN_CYCLES=0) runs
// free for 70000 edges to show the run never ends and cycle_count saturates.
// The reference model derives every output from the number of effective
// (unpaused) edges since the last reset or restart.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // dut1: defaults
  logic        rst_n = 1'b0;
  logic        soft_restart = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  channel_reset;
  logic [1:0]  phase;
  logic        run_active;
  logic        done;
  logic [15:0] cycle_count;

  // dut2: four channels, run forever
  logic        rst2_n = 1'b0;
  logic        soft_restart2 = 1'b0;
  logic        pause2 = 1'b0;
  logic [3:0]  channel_reset2;
  logic [1:0]  phase2;
  logic        run_active2;
  logic        done2;
  logic [15:0] cycle_count2;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint e1 = 0;
  longint e2 = 0;

  reset_sequencer dut1 (
    .clock         (clk),
    .reset         (rst_n),
    .soft_restart  (soft_restart),
    .pause         (pause),
    .channel_reset (channel_reset),
    .phase         (phase),
    .run_active    (run_active),
    .done          (done),
    .cycle_count   (cycle_count)
  );

  reset_sequencer #(
    .CHANNELS    (4),
    .HOLD_CYCLES (10),
    .STAGE_GAP   (1),
    .RUN_CYCLES  (0),
    .CNT_WIDTH   (16)
  ) dut2 (
    .clock         (clk),
    .reset         (rst2_n),
    .soft_restart  (soft_restart2),
    .pause         (pause2),
    .channel_reset (channel_reset2),
    .phase         (phase2),
    .run_active    (run_active2),
    .done          (done2),
    .cycle_count   (cycle_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Layout: phase[41:40] channels[39:32] run_active[17] done[16] count[15:0]
  function automatic logic [63:0] pack(input logic [1:0] ph, input logic [7:0] ch,
                                       input logic ra, input logic dn,
                                       input logic [15:0] cnt);
    return {22'd0, ph, ch, 14'd0, ra, dn, cnt};
  endfunction

  // Expected outputs after e effective edges.
  function automatic logic [63:0] model(input longint e, input longint ch,
                                        input longint hold, input longint gap,
                                        input longint run);
    longint     s;
    longint     c;
    logic [7:0] bits;
    logic       dn;
    logic [1:0] ph;
    s    = hold + (ch - 1) * gap;       // edge at which the last channel frees
    bits = '0;
    for (int k = 0; k < ch; k++) bits[k] = (e >= hold + k * gap) ? 1'b0 : 1'b1;
    dn = (run != 0) && (e >= s + run);
    if (e < hold)     ph = 2'd0;
    else if (e < s)   ph = 2'd1;
    else if (dn)      ph = 2'd3;
    else              ph = 2'd2;
    c = '0;
    if (e >= s) c = e - s;
    if (run != 0 && c > run) c = run;
    if (c > 65535) c = 65535;
    return pack(ph, bits, ph == 2'd2, dn, c[15:0]);
  endfunction

  function automatic logic [63:0] exp1(input longint e);
    return model(e, 2, 10, 4, 500);
  endfunction

  function automatic logic [63:0] obs1();
    return pack(phase, {6'd0, channel_reset}, run_active, done, cycle_count);
  endfunction

  function automatic logic [63:0] obs2();
    return pack(phase2, {4'd0, channel_reset2}, run_active2, done2, cycle_count2);
  endfunction

  // One clock of dut1: drive at the falling edge, update model at the rising
  // edge, compare at the next falling edge.
  task automatic tick1(input logic p, input logic s);
    pause        = p;
    soft_restart = s;
    @(posedge clk);
    if (s) e1 = 0;
    else if (!p) e1++;
    @(negedge clk);
    check($sformatf("dut1 e=%0d", e1), obs1(), exp1(e1));
  endtask

  // Sequence from a fresh start with idle inputs, with the milestone edges
  // checked against fixed expectations.
  task automatic run_default(input string name);
    for (int n = 1; n <= 520; n++) begin
      tick1(1'b0, 1'b0);
      if (n == 9)   check({name, " ch@9"},   64'(channel_reset), 64'h3);
      if (n == 10)  check({name, " ch@10"},  64'(channel_reset), 64'h2);
      if (n == 13)  check({name, " run@13"}, 64'(run_active),    64'h0);
      if (n == 14)  check({name, " ch@14"},  64'(channel_reset), 64'h0);
      if (n == 14)  check({name, " run@14"}, 64'(run_active),    64'h1);
      if (n == 513) check({name, " done@513"}, 64'(done), 64'h0);
      if (n == 514) check({name, " done@514"}, 64'(done), 64'h1);
      if (n == 514) check({name, " cnt@514"},  64'(cycle_count), 64'd500);
      if (n == 520) check({name, " cnt@520"},  64'(cycle_count), 64'd500);
    end
  endtask

  // Assert reset between clock edges, check immediately, release on a
  // falling edge.
  task automatic async_reset1(input string name);
    #3 rst_n = 1'b0;
    #1 check({name, " immediate"}, obs1(), exp1(0));
    e1 = 0;
    @(negedge clk);
    check({name, " held"}, obs1(), exp1(0));
    rst_n = 1'b1;
  endtask

  task automatic main_seq();
    repeat (2) @(negedge clk);
    check("dut1 reset values", obs1(), exp1(0));
    check("dut1 reset ch", 64'(channel_reset), 64'h3);
    rst_n = 1'b1;
    e1    = 0;

    run_default("idle");

    // Restart and pause together while in DONE.
    tick1(1'b1, 1'b1);
    check("restart in DONE phase", 64'(phase), 64'h0);
    check("restart in DONE done",  64'(done),  64'h0);

    // Pause over edges 12..16 defers channel 1 and done by five edges.
    for (int n = 1; n <= 520; n++) begin
      tick1(n >= 12 && n <= 16, 1'b0);
      if (n == 14)  check("pause ch@14",   64'(channel_reset), 64'h2);
      if (n == 18)  check("pause ch@18",   64'(channel_reset), 64'h2);
      if (n == 19)  check("pause ch@19",   64'(channel_reset), 64'h0);
      if (n == 518) check("pause done@518", 64'(done), 64'h0);
      if (n == 519) check("pause done@519", 64'(done), 64'h1);
    end

    // Fresh start, then soft_restart at edge 100 while in RUN.
    tick1(1'b0, 1'b1);
    for (int n = 1; n <= 199; n++) begin
      tick1(1'b0, n == 100);
      if (n == 99)  check("restart run@99",  64'(run_active), 64'h1);
      if (n == 100) check("restart ch@100",  64'(channel_reset), 64'h3);
      if (n == 100) check("restart ph@100",  64'(phase), 64'h0);
      if (n == 109) check("restart ch@109",  64'(channel_reset), 64'h3);
      if (n == 110) check("restart ch@110",  64'(channel_reset), 64'h2);
      if (n == 114) check("restart ch@114",  64'(channel_reset), 64'h0);
    end

    // Asynchronous reset 5 ns after edge 200.
    pause        = 1'b0;
    soft_restart = 1'b0;
    @(posedge clk);
    e1++;
    #5 rst_n = 1'b0;
    #1 check("async reset @200+5ns", obs1(), exp1(0));
    e1 = 0;
    @(negedge clk);
    check("async reset held", obs1(), exp1(0));
    rst_n = 1'b1;
    run_default("replay");

    // Random pause, restart and reset traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1999) == 0) async_reset1("random reset");
      else tick1($urandom_range(0, 4) == 0, $urandom_range(0, 1499) == 0);
    end
  endtask

  task automatic big_seq();
    logic seen_done;
    seen_done = 1'b0;
    repeat (2) @(negedge clk);
    check("dut2 reset values", obs2(), model(0, 4, 10, 1, 0));
    rst2_n = 1'b1;
    e2     = 0;
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      e2++;
      @(negedge clk);
      check($sformatf("dut2 e=%0d", e2), obs2(), model(e2, 4, 10, 1, 0));
      if (done2) seen_done = 1'b1;
      if (n == 10) check("dut2 ch@10", 64'(channel_reset2), 64'hE);
      if (n == 11) check("dut2 ch@11", 64'(channel_reset2), 64'hC);
      if (n == 12) check("dut2 ch@12", 64'(channel_reset2), 64'h8);
      if (n == 13) check("dut2 ch@13", 64'(channel_reset2), 64'h0);
    end
    check("dut2 done never", 64'(seen_done), 64'h0);
    check("dut2 saturated", 64'(cycle_count2), 64'hFFFF);
    check("dut2 still run", 64'(run_active2), 64'h1);
  endtask

  initial begin
    fork
      main_seq();
      big_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
